// File: rtl/window_counter.sv
// window_counter: walks a WINDOW_SIZE x WINDOW_SIZE neighbourhood in row-major
// order (X fastest), one coordinate per clock. It feeds the median-filter
// window fetch and sort logic.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   start       - level request to scan one window (sampled in IDLE/DONE only)
//   countX      - column index within the window, 0..WINDOW_SIZE-1
//   countY      - row index within the window, 0..WINDOW_SIZE-1
//   windowValid - qualifies countX/countY
//
// All outputs are registered. The next-state logic computes the next output
// values, and a single register stage holds them, so there is no
// combinational path from start to any output.
module window_counter #(
  parameter int WINDOW_SIZE = 3,
  parameter int CNT_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [CNT_W-1:0] countX,
  output logic [CNT_W-1:0] countY,
  output logic             windowValid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_SIZE - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic             vld_nxt;
  logic             xDone, yDone;

  assign xDone = (countX == LAST);
  assign yDone = (countY == LAST);

  // Counts default to 0 and valid defaults to low. Only SCAN (or a start
  // accepted in IDLE/DONE) produces a valid coordinate. The unused encoding
  // falls through to IDLE with cleared counts.
  always_comb begin
    state_nxt = IDLE;
    x_nxt     = '0;
    y_nxt     = '0;
    vld_nxt   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SCAN;
          vld_nxt   = 1'b1;
        end
      end
      SCAN: begin
        if (xDone && yDone) begin
          // Last coordinate. Spend one invalid cycle in DONE.
          state_nxt = DONE;
        end else begin
          state_nxt = SCAN;
          vld_nxt   = 1'b1;
          if (xDone) begin
            y_nxt = countY + 1'b1;
          end else begin
            x_nxt = countX + 1'b1;
            y_nxt = countY;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      countX      <= '0;
      countY      <= '0;
      windowValid <= 1'b0;
    end else begin
      state       <= state_nxt;
      countX      <= x_nxt;
      countY      <= y_nxt;
      windowValid <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_window_counter.sv
// Directed bench for window_counter. It uses a 3x3 instance and a 4x4
// instance, and the two instances share the clock and reset.
module tb_window_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start4;
  logic [1:0] countX, countY, countX4, countY4;
  logic       windowValid, windowValid4;

  int n_chk  = 0;
  int n_fail = 0;

  window_counter #(.WINDOW_SIZE(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .countX(countX), .countY(countY), .windowValid(windowValid)
  );

  window_counter #(.WINDOW_SIZE(4), .CNT_W(2)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .countX(countX4), .countY(countY4), .windowValid(windowValid4)
  );

  always #5 clk = ~clk;

  // Hand-written row-major order for a 3x3 window.
  int xs3[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int ys3[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};

  function automatic int pk(int x, int y, int v);
    return y * 8 + x * 2 + v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got y%0d x%0d v%0d, want y%0d x%0d v%0d", tag,
               obs / 8, (obs / 2) % 4, obs % 2, exp / 8, (exp / 2) % 4, exp % 2);
    end
  endtask

  function automatic int obs3();
    return pk(int'(countX), int'(countY), int'(windowValid));
  endfunction

  function automatic int obs4();
    return pk(int'(countX4), int'(countY4), int'(windowValid4));
  endfunction

  // Sample 1 time unit after the rising edge. Inputs changed here are stable
  // well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b1;
    start4 = 1'b1;

    // Reset held with start high: outputs stay cleared.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_hold%0d", i), obs3(), pk(0, 0, 0));
    end
    chk("rst_hold_ws4", obs4(), pk(0, 0, 0));

    // Release reset with start low: no activity.
    start  = 1'b0;
    start4 = 1'b0;
    reset  = 1'b1;
    tick();
    chk("idle_after_rst", obs3(), pk(0, 0, 0));

    // Single scan from a one-cycle start pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("single0", obs3(), pk(0, 0, 1));
    for (int i = 1; i < 9; i++) begin
      tick();
      chk($sformatf("single%0d", i), obs3(), pk(xs3[i], ys3[i], 1));
    end
    tick();
    chk("single_done", obs3(), pk(0, 0, 0));
    tick();
    chk("single_idle", obs3(), pk(0, 0, 0));

    // Start held for 30 cycles: 9 valid + 1 gap, repeating.
    start = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (n % 10 == 9)
        chk($sformatf("cont%0d", n), obs3(), pk(0, 0, 0));
      else
        chk($sformatf("cont%0d", n), obs3(), pk(xs3[n % 10], ys3[n % 10], 1));
    end
    start = 1'b0;
    tick();
    chk("cont_idle", obs3(), pk(0, 0, 0));

    // Start dropped at (1,1): the scan still completes.
    start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk($sformatf("drop%0d", i), obs3(), pk(xs3[i], ys3[i], 1));
      if (i == 4) start = 1'b0;
    end
    tick();
    chk("drop_done", obs3(), pk(0, 0, 0));
    tick();
    chk("drop_idle", obs3(), pk(0, 0, 0));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart0", obs3(), pk(0, 0, 1));
    tick();
    chk("restart1", obs3(), pk(1, 0, 1));
    tick();
    chk("restart2", obs3(), pk(2, 0, 1));

    // Async reset at (2,0), between edges.
    #2 reset = 1'b0;
    #1;
    chk("async_rst", obs3(), pk(0, 0, 0));
    tick();
    chk("rst_low_edge", obs3(), pk(0, 0, 0));
    reset = 1'b1;
    tick();
    chk("post_rst_idle0", obs3(), pk(0, 0, 0));
    tick();
    chk("post_rst_idle1", obs3(), pk(0, 0, 0));
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_rst_scan", obs3(), pk(0, 0, 1));
    for (int i = 1; i < 9; i++) tick();
    chk("post_rst_last", obs3(), pk(2, 2, 1));
    tick();
    chk("post_rst_done", obs3(), pk(0, 0, 0));

    // 4x4 window: 16 valid cycles, then DONE.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("ws4_0", obs4(), pk(0, 0, 1));
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("ws4_%0d", i), obs4(), pk(i % 4, i / 4, 1));
    end
    tick();
    chk("ws4_done", obs4(), pk(0, 0, 0));
    tick();
    chk("ws4_idle", obs4(), pk(0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
